// File: rtl/contador_ud_param.sv
// contador_ud_param: modular up/down counter with load, optional Gray output, tc and wrap.
// Define CONTADOR_UD_SAT_EN to saturate at the count boundaries instead of wrapping.
module contador_ud_param #(
    parameter int WIDTH     = 3,
    parameter int MODULO    = 8,
    parameter int RESET_VAL = 0,
    parameter int GRAY      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] ea,
    output logic [WIDTH-1:0] pe,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MOD = (WIDTH+1)'(MODULO);

    logic [WIDTH-1:0] cnt, nxt, step, clip;
    logic             at_top, at_bot;

    function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] v);
        return (GRAY != 0) ? (v ^ (v >> 1)) : v;
    endfunction

    always_comb begin
        at_top = (cnt == MAX);
        at_bot = (cnt == '0);
        tc     = en & ~load & (up ? at_top : at_bot);
        // Loads beyond the modulus clip so unreachable states stay unreachable
        clip   = ({1'b0, load_val} >= MOD) ? MAX : load_val;
`ifdef CONTADOR_UD_SAT_EN
        step   = tc ? cnt : (up ? cnt + 1'b1 : cnt - 1'b1);
`else
        step   = up ? (at_top ? '0 : cnt + 1'b1) : (at_bot ? MAX : cnt - 1'b1);
`endif
        nxt    = load ? clip : (en ? step : cnt);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= RST;
        else        cnt <= nxt;

`ifdef CONTADOR_UD_SAT_EN
    assign wrap = 1'b0;
`else
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wrap <= 1'b0;
        else        wrap <= tc;
`endif

    assign ea = enc(cnt);
    assign pe = enc(nxt);
endmodule

// File: tb/tb_contador_ud_param.sv
// tb_contador_ud_param: directed vector and sequence checks for contador_ud_param.
module tb_contador_ud_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, up = 1'b0, load = 1'b0;
    logic [3:0] lv = '0;
    logic [2:0] ea0, pe0, ea2, pe2;
    logic [3:0] ea1, pe1;
    logic       tc0, tc1, tc2, wrap0, wrap1, wrap2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    contador_ud_param #(.WIDTH(3), .MODULO(8), .RESET_VAL(0), .GRAY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(lv[2:0]),
        .ea(ea0), .pe(pe0), .tc(tc0), .wrap(wrap0));
    contador_ud_param #(.WIDTH(4), .MODULO(10), .RESET_VAL(0), .GRAY(0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(lv),
        .ea(ea1), .pe(pe1), .tc(tc1), .wrap(wrap1));
    contador_ud_param #(.WIDTH(3), .MODULO(8), .RESET_VAL(0), .GRAY(1)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(lv[2:0]),
        .ea(ea2), .pe(pe2), .tc(tc2), .wrap(wrap2));

    typedef struct {
        logic       en, up, load;
        logic [2:0] lv, ea, pe;
        logic       tc, wrap;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        en = 0; up = 0; load = 0; lv = '0; rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst ea0", ea0, 0); chk("rst wrap0", wrap0, 0);
        chk("rst ea1", ea1, 0); chk("rst ea2", ea2, 0);
        rst_n = 1;
    endtask

    initial begin
        vec_t       v[21];
        logic [2:0] g[8];
        logic [2:0] prev;
        int         e;
`ifdef CONTADOR_UD_SAT_EN
        do_reset();
        en = 1; up = 1;
        for (int k = 0; k < 10; k++) begin
            e = (k > 7) ? 7 : k;
            #1;
            chk($sformatf("sat ea k%0d", k), ea0, e);
            chk($sformatf("sat tc k%0d", k), tc0, int'(k >= 7));
            chk($sformatf("sat wrap k%0d", k), wrap0, 0);
            @(negedge clk);
        end
        up = 0;
        #1 chk("sat hold ea", ea0, 7);
        @(negedge clk);
        #1 chk("sat down ea", ea0, 6);
        chk("sat down wrap", wrap0, 0);
`else
        // en, up, load, load_val, ea, pe, tc, wrap
        v[0]  = '{1, 1, 0, 0, 0, 1, 0, 0};
        v[1]  = '{1, 1, 0, 0, 1, 2, 0, 0};
        v[2]  = '{1, 1, 0, 0, 2, 3, 0, 0};
        v[3]  = '{1, 1, 0, 0, 3, 4, 0, 0};
        v[4]  = '{1, 1, 0, 0, 4, 5, 0, 0};
        v[5]  = '{1, 1, 0, 0, 5, 6, 0, 0};
        v[6]  = '{1, 1, 0, 0, 6, 7, 0, 0};
        v[7]  = '{1, 1, 0, 0, 7, 0, 1, 0};
        v[8]  = '{1, 1, 0, 0, 0, 1, 0, 1};
        v[9]  = '{1, 1, 1, 5, 1, 5, 0, 0};
        v[10] = '{0, 1, 0, 0, 5, 5, 0, 0};
        v[11] = '{1, 0, 0, 0, 5, 4, 0, 0};
        v[12] = '{0, 0, 1, 7, 4, 7, 0, 0};
        v[13] = '{1, 1, 1, 2, 7, 2, 0, 0};
        v[14] = '{1, 0, 0, 0, 2, 1, 0, 0};
        v[15] = '{1, 0, 0, 0, 1, 0, 0, 0};
        v[16] = '{1, 0, 0, 0, 0, 7, 1, 0};
        v[17] = '{1, 1, 0, 0, 7, 0, 1, 1};
        v[18] = '{0, 1, 0, 0, 0, 0, 0, 1};
        v[19] = '{0, 1, 0, 0, 0, 0, 0, 0};
        v[20] = '{0, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 21; i++) begin
            en = v[i].en; up = v[i].up; load = v[i].load; lv = {1'b0, v[i].lv};
            #1;
            chk($sformatf("vec%0d ea", i), ea0, v[i].ea);
            chk($sformatf("vec%0d pe", i), pe0, v[i].pe);
            chk($sformatf("vec%0d tc", i), tc0, v[i].tc);
            chk($sformatf("vec%0d wrap", i), wrap0, v[i].wrap);
            @(negedge clk);
        end

        // Modulo-10 down count: 0,9,8,...,0
        do_reset();
        en = 1; up = 0;
        for (int k = 0; k <= 10; k++) begin
            e = (k == 0) ? 0 : 10 - k;
            #1;
            chk($sformatf("m10 ea k%0d", k), ea1, e);
            chk($sformatf("m10 tc k%0d", k), tc1, int'(e == 0));
            chk($sformatf("m10 wrap k%0d", k), wrap1, int'(k == 1));
            @(negedge clk);
        end
        en = 0; load = 1; lv = 4'd13;
        #1 chk("m10 clip pe", pe1, 9);
        @(negedge clk);
        #1 chk("m10 clip ea", ea1, 9);
        en = 1; up = 1; lv = 4'd3;
        #1 chk("m10 load tc", tc1, 0);
        chk("m10 load pe", pe1, 3);
        @(negedge clk);
        load = 0; en = 0;
        #1 chk("m10 load ea", ea1, 3);
        chk("m10 load wrap", wrap1, 0);
        @(negedge clk);

        // Gray sequence, one bit per step including the wrap
        g = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        do_reset();
        en = 1; up = 1; prev = '0;
        for (int k = 0; k <= 8; k++) begin
            #1;
            chk($sformatf("gray ea k%0d", k), ea2, g[k % 8]);
            chk($sformatf("gray pe k%0d", k), pe2, g[(k + 1) % 8]);
            if (k > 0) chk($sformatf("gray 1bit k%0d", k), $countones(ea2 ^ prev), 1);
            prev = ea2;
            @(negedge clk);
        end

        // Asynchronous reset between edges
        do_reset();
        en = 1; up = 1;
        repeat (5) @(negedge clk);
        #1 chk("ar pre ea", ea0, 5);
        #1 rst_n = 0;
        #1 chk("ar ea", ea0, 0);
        chk("ar wrap", wrap0, 0);
        #1 rst_n = 1;
        @(negedge clk);
        #1 chk("ar resume ea", ea0, 1);
        repeat (7) @(negedge clk);
        #1 chk("ar wrap pre ea", ea0, 0);
        chk("ar wrap pre", wrap0, 1);
        #1 rst_n = 0;
        #1 chk("ar wrap clr", wrap0, 0);
        rst_n = 1;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
